// File: rtl/bird_launch_seq_pkg.sv
// Shared game definitions: bird state encodings, aim-key bit order and the
// aim direction decode used by the bird, pig and collision blocks.
package bird_launch_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOAD = 2'd0,
    ST_LOADING   = 2'd1,
    ST_AIM       = 2'd2,
    ST_FLYING    = 2'd3
  } bird_state_e;

  // Bit positions of the aim keys inside a packed 4-bit key vector.
  localparam int KEY_W = 0;
  localparam int KEY_A = 1;
  localparam int KEY_S = 2;
  localparam int KEY_D = 3;

  typedef enum logic [1:0] {
    AIM_HOLD = 2'd0,
    AIM_DEC  = 2'd1,
    AIM_INC  = 2'd2
  } aim_dir_e;

  // Opposing keys together cancel, exactly like no key at all.
  function automatic aim_dir_e aim_dir(input logic dec, input logic inc);
    aim_dir_e dir;
    case ({dec, inc})
      2'b10:   dir = AIM_DEC;
      2'b01:   dir = AIM_INC;
      default: dir = AIM_HOLD;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/bird_launch_seq_aim_axis.sv
// One aim axis: steps the current offset by +/-AIM_STEP and saturates to
// [-AIM_MAX, +AIM_MAX]; computed one bit wider so the clamp never sees a wrap.
module aim_axis
  import bird_launch_seq_pkg::*;
#(
  parameter int AIM_W    = 17,
  parameter int AIM_MAX  = 63,
  parameter int AIM_STEP = 1
) (
  input  logic [AIM_W-1:0] cur,
  input  logic             dec,
  input  logic             inc,
  output logic [AIM_W-1:0] nxt
);

  localparam int EW = AIM_W + 1;
  localparam logic signed [EW-1:0] STEP_X = EW'(AIM_STEP);
  localparam logic signed [EW-1:0] MAX_X  = EW'(AIM_MAX);
  localparam logic signed [EW-1:0] MIN_X  = -MAX_X;

  logic signed [EW-1:0] cur_x;
  logic signed [EW-1:0] sum_x;

  // Sign-extend, step, then clamp back into the legal window.
  always_comb begin
    cur_x = $signed({cur[AIM_W-1], cur});
    case (aim_dir(dec, inc))
      AIM_DEC: sum_x = cur_x - STEP_X;
      AIM_INC: sum_x = cur_x + STEP_X;
      default: sum_x = cur_x;
    endcase
    if (sum_x > MAX_X) begin
      nxt = MAX_X[AIM_W-1:0];
    end else if (sum_x < MIN_X) begin
      nxt = MIN_X[AIM_W-1:0];
    end else begin
      nxt = sum_x[AIM_W-1:0];
    end
  end

endmodule

// File: rtl/bird_launch_seq.sv
// Bird launch sequencer: load animation, aiming, flight timing and round
// bookkeeping, all advancing only on frame ticks.
module bird_launch_seq
  import bird_launch_seq_pkg::*;
#(
  parameter int NUM_BIRDS   = 3,
  parameter int LOAD_FRAMES = 32,
  parameter int FLY_FRAMES  = 481,
  parameter int AIM_W       = 17,
  parameter int AIM_MAX     = 63,
  parameter int AIM_STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             launch,
  input  logic             key_w,
  input  logic             key_a,
  input  logic             key_s,
  input  logic             key_d,
  input  logic             settled,
  input  logic             restart,
  output logic [1:0]       bird_state,
  output logic [2:0]       active_bird,
  output logic             all_done,
  output logic [9:0]       anim_cnt,
  output logic [AIM_W-1:0] delta_x,
  output logic [AIM_W-1:0] delta_y,
  output logic [AIM_W-1:0] shot_dx,
  output logic [AIM_W-1:0] shot_dy,
  output logic             launch_pulse,
  output logic [3:0]       birds_left
);

  localparam logic [9:0] LOAD_LAST  = 10'(LOAD_FRAMES - 1);
  localparam logic [9:0] FLY_LAST   = 10'(FLY_FRAMES - 1);
  localparam logic [2:0] LAST_BIRD  = 3'(NUM_BIRDS - 1);
  localparam logic [3:0] BIRDS_INIT = 4'(NUM_BIRDS);

  bird_state_e      state_q, state_d;
  logic [2:0]       active_q, active_d;
  logic             done_q, done_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [AIM_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [AIM_W-1:0] sdx_q, sdx_d, sdy_q, sdy_d;
  logic             pulse_q, pulse_d;
  logic [3:0]       left_q, left_d;
  logic             lpend_q, lpend_d, rpend_q, rpend_d;

  logic [3:0]       keys_s;
  logic [AIM_W-1:0] dx_nxt_s, dy_nxt_s;
  logic             launch_go_s, restart_go_s;

  // Pack the key levels in the shared bit order.
  always_comb begin
    keys_s        = 4'd0;
    keys_s[KEY_W] = key_w;
    keys_s[KEY_A] = key_a;
    keys_s[KEY_S] = key_s;
    keys_s[KEY_D] = key_d;
  end

  aim_axis #(.AIM_W(AIM_W), .AIM_MAX(AIM_MAX), .AIM_STEP(AIM_STEP)) u_axis_x (
    .cur (dx_q),
    .dec (keys_s[KEY_A]),
    .inc (keys_s[KEY_D]),
    .nxt (dx_nxt_s)
  );

  aim_axis #(.AIM_W(AIM_W), .AIM_MAX(AIM_MAX), .AIM_STEP(AIM_STEP)) u_axis_y (
    .cur (dy_q),
    .dec (keys_s[KEY_W]),
    .inc (keys_s[KEY_S]),
    .nxt (dy_nxt_s)
  );

  // Next-state logic; a request arriving on the tick clk itself counts as pending.
  always_comb begin
    launch_go_s  = lpend_q | launch;
    restart_go_s = rpend_q | restart;
    state_d  = state_q;
    active_d = active_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sdx_d    = sdx_q;
    sdy_d    = sdy_q;
    left_d   = left_q;
    pulse_d  = 1'b0;
    lpend_d  = launch_go_s;
    rpend_d  = restart_go_s;
    if (frame_tick) begin
      lpend_d = 1'b0;
      rpend_d = 1'b0;
      if (restart_go_s) begin
        state_d  = ST_WAIT_LOAD;
        active_d = 3'd0;
        done_d   = 1'b0;
        cnt_d    = 10'd0;
        dx_d     = '0;
        dy_d     = '0;
        sdx_d    = '0;
        sdy_d    = '0;
        left_d   = BIRDS_INIT;
      end else begin
        case (state_q)
          ST_WAIT_LOAD: begin
            if (done_q) begin
              state_d = ST_WAIT_LOAD;
            end else begin
              state_d = ST_LOADING;
              cnt_d   = 10'd0;
            end
          end
          ST_LOADING: begin
            if (cnt_q == LOAD_LAST) begin
              state_d = ST_AIM;
              cnt_d   = 10'd0;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
          ST_AIM: begin
            if (launch_go_s) begin
              state_d = ST_FLYING;
              sdx_d   = dx_nxt_s;
              sdy_d   = dy_nxt_s;
              dx_d    = '0;
              dy_d    = '0;
              cnt_d   = 10'd0;
              left_d  = left_q - 4'd1;
              pulse_d = 1'b1;
            end else begin
              dx_d = dx_nxt_s;
              dy_d = dy_nxt_s;
            end
          end
          ST_FLYING: begin
            if ((cnt_q == FLY_LAST) || settled) begin
              state_d = ST_WAIT_LOAD;
              cnt_d   = 10'd0;
              if (active_q < LAST_BIRD) begin
                active_d = active_q + 3'd1;
              end else begin
                done_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
          default: begin
            state_d = ST_WAIT_LOAD;
            cnt_d   = 10'd0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WAIT_LOAD;
      active_q <= 3'd0;
      done_q   <= 1'b0;
      cnt_q    <= 10'd0;
      dx_q     <= '0;
      dy_q     <= '0;
      sdx_q    <= '0;
      sdy_q    <= '0;
      pulse_q  <= 1'b0;
      left_q   <= BIRDS_INIT;
      lpend_q  <= 1'b0;
      rpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sdx_q    <= sdx_d;
      sdy_q    <= sdy_d;
      pulse_q  <= pulse_d;
      left_q   <= left_d;
      lpend_q  <= lpend_d;
      rpend_q  <= rpend_d;
    end
  end

  assign bird_state   = state_q;
  assign active_bird  = active_q;
  assign all_done     = done_q;
  assign anim_cnt     = cnt_q;
  assign delta_x      = dx_q;
  assign delta_y      = dy_q;
  assign shot_dx      = sdx_q;
  assign shot_dy      = sdy_q;
  assign launch_pulse = pulse_q;
  assign birds_left   = left_q;

endmodule

// File: tb/tb_bird_launch_seq.sv
// Bench for bird_launch_seq: a frame-level behavioural model checked every
// clk, plus hand-computed expectations at the scenario milestones.
module tb_bird_launch_seq;

  localparam int NUM_BIRDS   = 3;
  localparam int LOAD_FRAMES = 32;
  localparam int FLY_FRAMES  = 481;
  localparam int AIM_W       = 17;
  localparam int AIM_MAX     = 63;
  localparam int AIM_STEP    = 1;

  logic clk = 1'b0;
  logic rst;
  logic frame_tick, launch, key_w, key_a, key_s, key_d, settled, restart;
  logic [1:0]       bird_state;
  logic [2:0]       active_bird;
  logic             all_done;
  logic [9:0]       anim_cnt;
  logic [AIM_W-1:0] delta_x, delta_y, shot_dx, shot_dy;
  logic             launch_pulse;
  logic [3:0]       birds_left;

  bird_launch_seq #(
    .NUM_BIRDS(NUM_BIRDS), .LOAD_FRAMES(LOAD_FRAMES), .FLY_FRAMES(FLY_FRAMES),
    .AIM_W(AIM_W), .AIM_MAX(AIM_MAX), .AIM_STEP(AIM_STEP)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
    .key_w(key_w), .key_a(key_a), .key_s(key_s), .key_d(key_d),
    .settled(settled), .restart(restart),
    .bird_state(bird_state), .active_bird(active_bird), .all_done(all_done),
    .anim_cnt(anim_cnt), .delta_x(delta_x), .delta_y(delta_y),
    .shot_dx(shot_dx), .shot_dy(shot_dy), .launch_pulse(launch_pulse),
    .birds_left(birds_left)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model (one step per clk edge) ----------------
  localparam int S_WAIT = 0, S_LOAD = 1, S_AIM = 2, S_FLY = 3;
  int m_state, m_cnt, m_ab, m_dx, m_dy, m_sdx, m_sdy, m_left;
  bit m_done, m_pulse, m_lpend, m_rpend;

  function automatic int clamp(input int v);
    if (v > AIM_MAX) return AIM_MAX;
    if (v < -AIM_MAX) return -AIM_MAX;
    return v;
  endfunction

  task automatic m_reset();
    m_state = S_WAIT; m_cnt = 0; m_ab = 0; m_done = 0;
    m_dx = 0; m_dy = 0; m_sdx = 0; m_sdy = 0;
    m_left = NUM_BIRDS; m_pulse = 0; m_lpend = 0; m_rpend = 0;
  endtask

  task automatic m_step();
    bit lp, rp;
    lp = m_lpend || launch;
    rp = m_rpend || restart;
    m_pulse = 0;
    if (!frame_tick) begin
      m_lpend = lp;
      m_rpend = rp;
    end else begin
      m_lpend = 0;
      m_rpend = 0;
      if (rp) begin
        m_reset();
      end else if (m_done) begin
        m_state = S_WAIT;
      end else if (m_state == S_WAIT) begin
        m_state = S_LOAD; m_cnt = 0;
      end else if (m_state == S_LOAD) begin
        if (m_cnt == LOAD_FRAMES - 1) begin m_state = S_AIM; m_cnt = 0; end
        else m_cnt++;
      end else if (m_state == S_AIM) begin
        m_dx = clamp(m_dx + AIM_STEP * (int'(key_d) - int'(key_a)));
        m_dy = clamp(m_dy + AIM_STEP * (int'(key_s) - int'(key_w)));
        if (lp) begin
          m_sdx = m_dx; m_sdy = m_dy; m_dx = 0; m_dy = 0;
          m_cnt = 0; m_left--; m_pulse = 1; m_state = S_FLY;
        end
      end else begin
        if (m_cnt == FLY_FRAMES - 1 || settled) begin
          m_cnt = 0; m_state = S_WAIT;
          if (m_ab < NUM_BIRDS - 1) m_ab++;
          else m_done = 1;
        end else m_cnt++;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  // Every-clk comparison of all outputs against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("m_state",  int'(bird_state),       m_state);
        chk("m_active", int'(active_bird),      m_ab);
        chk("m_done",   int'(all_done),         int'(m_done));
        chk("m_cnt",    int'(anim_cnt),         m_cnt);
        chk("m_dx",     int'($signed(delta_x)), m_dx);
        chk("m_dy",     int'($signed(delta_y)), m_dy);
        chk("m_sdx",    int'($signed(shot_dx)), m_sdx);
        chk("m_sdy",    int'($signed(shot_dy)), m_sdy);
        chk("m_pulse",  int'(launch_pulse),     int'(m_pulse));
        chk("m_left",   int'(birds_left),       m_left);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic req_launch();
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    @(negedge clk);
  endtask

  task automatic lit_reset(input string tag);
    chk({tag, "_state"}, int'(bird_state), 0);
    chk({tag, "_active"}, int'(active_bird), 0);
    chk({tag, "_done"}, int'(all_done), 0);
    chk({tag, "_cnt"}, int'(anim_cnt), 0);
    chk({tag, "_dx"}, int'($signed(delta_x)), 0);
    chk({tag, "_dy"}, int'($signed(delta_y)), 0);
    chk({tag, "_sdx"}, int'($signed(shot_dx)), 0);
    chk({tag, "_sdy"}, int'($signed(shot_dy)), 0);
    chk({tag, "_pulse"}, int'(launch_pulse), 0);
    chk({tag, "_left"}, int'(birds_left), 3);
  endtask

  initial begin
    frame_tick = 1'b0; launch = 1'b0; settled = 1'b0; restart = 1'b0;
    key_w = 1'b0; key_a = 1'b0; key_s = 1'b0; key_d = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    lit_reset("rst_hold");
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_adv_before_tick", int'(bird_state), 0);

    // Load sequence: 1 tick in WAIT_LOAD, 32 in LOADING, AIM on tick 33.
    tick_n(1);
    chk("t1_state", int'(bird_state), 1);
    chk("t1_cnt", int'(anim_cnt), 0);
    tick_n(31);
    chk("t32_state", int'(bird_state), 1);
    chk("t32_cnt", int'(anim_cnt), 31);
    tick_n(1);
    chk("t33_state", int'(bird_state), 2);
    chk("t33_cnt", int'(anim_cnt), 0);

    // Aiming with saturation and cancelling keys.
    key_d = 1'b1; tick_n(70);
    chk("dx_sat_pos", int'($signed(delta_x)), 63);
    key_d = 1'b0; key_w = 1'b1; tick_n(5);
    chk("dy_w5", int'($signed(delta_y)), -5);
    chk("dx_held", int'($signed(delta_x)), 63);
    key_w = 1'b0; key_a = 1'b1; key_d = 1'b1; tick_n(3);
    chk("dx_ad_cancel", int'($signed(delta_x)), 63);
    key_d = 1'b0; tick_n(130);
    chk("dx_sat_neg", int'($signed(delta_x)), -63);
    key_a = 1'b0; key_d = 1'b1; tick_n(73);
    key_d = 1'b0; key_w = 1'b1; key_s = 1'b1; tick_n(2);
    chk("dy_ws_cancel", int'($signed(delta_y)), -5);
    key_w = 1'b0; tick_n(1);
    key_s = 1'b0;
    chk("dx_10", int'($signed(delta_x)), 10);
    chk("dy_m4", int'($signed(delta_y)), -4);

    // Launch between ticks.
    req_launch();
    chk("pre_launch_state", int'(bird_state), 2);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("l_pulse", int'(launch_pulse), 1);
    chk("l_state", int'(bird_state), 3);
    chk("l_sdx", int'($signed(shot_dx)), 10);
    chk("l_sdy", int'($signed(shot_dy)), -4);
    chk("l_dx0", int'($signed(delta_x)), 0);
    chk("l_left", int'(birds_left), 2);
    @(negedge clk);
    chk("l_pulse_end", int'(launch_pulse), 0);

    // Full-length flight.
    tick_n(480);
    chk("fly480_state", int'(bird_state), 3);
    chk("fly480_cnt", int'(anim_cnt), 480);
    tick_n(1);
    chk("fly_end_state", int'(bird_state), 0);
    chk("fly_end_active", int'(active_bird), 1);

    // Bird 2: launch during LOADING is dropped; settled ends flight early.
    tick_n(32);
    req_launch();
    tick_n(1);
    tick_n(2);
    chk("stale_launch_drop", int'(bird_state), 2);
    req_launch();
    tick_n(1);
    chk("b2_left", int'(birds_left), 1);
    tick_n(20);
    chk("b2_cnt20", int'(anim_cnt), 20);
    settled = 1'b1; tick_n(1); settled = 1'b0;
    chk("b2_settle_state", int'(bird_state), 0);
    chk("b2_settle_active", int'(active_bird), 2);

    // Bird 3 finishes the round.
    tick_n(33);
    req_launch();
    tick_n(6);
    settled = 1'b1; tick_n(1); settled = 1'b0;
    chk("done_flag", int'(all_done), 1);
    chk("done_left", int'(birds_left), 0);
    chk("done_state", int'(bird_state), 0);
    req_launch();
    tick_n(40);
    chk("done_ignore_launch", int'(bird_state), 0);
    chk("done_still", int'(all_done), 1);

    // Restart.
    restart = 1'b1; @(negedge clk); restart = 1'b0; @(negedge clk);
    tick_n(1);
    chk("rs_active", int'(active_bird), 0);
    chk("rs_left", int'(birds_left), 3);
    chk("rs_done", int'(all_done), 0);
    chk("rs_sdx", int'($signed(shot_dx)), 0);
    tick_n(34);
    key_d = 1'b1; tick_n(4); key_d = 1'b0;
    req_launch();
    tick_n(11);
    chk("rs_fly_cnt", int'(anim_cnt), 10);
    chk("rs_fly_sdx", int'($signed(shot_dx)), 4);

    // Asynchronous reset mid-flight on a non-tick clk.
    #2 rst = 1'b0;
    #1 lit_reset("async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bird_launch_seq.md
BIRD_LAUNCH_SEQ -- requirements
Module: bird_launch_seq

Interface
REQ-001 SHALL have parameter NUM_BIRDS, default 3, birds per round (legal 1..8).
REQ-002 SHALL have parameter LOAD_FRAMES, default 32, frames spent in load animation (legal 2..1023).
REQ-003 SHALL have parameter FLY_FRAMES, default 481, maximum frames a bird flies (legal 2..1023).
REQ-004 SHALL have parameter AIM_W, default 17, signed width of aim deltas.
REQ-005 SHALL have parameter AIM_MAX, default 63, aim magnitude limit per axis (legal 1..2^(AIM_W-1)-1).
REQ-006 SHALL have parameter AIM_STEP, default 1, aim change per frame per axis.
REQ-007 Ports SHALL be as follows:
 clk  in  1  system clock; sole clock.
 rst  in  1  asynchronous, active-low reset (0 = reset).
 frame_tick  in  1  one-clk pulse per video frame.
 launch  in  1  one-clk fire request; may arrive on any clk.
 key_w, key_a, key_s, key_d  in  1 each  level aim keys (W=up, S=down, A=left, D=right).
 settled  in  1  level; active bird has come to rest.
 restart  in  1  one-clk request; may arrive on any clk.
 bird_state  out  2  0=WAIT_LOAD, 1=LOADING, 2=AIM, 3=FLYING.
 active_bird  out  3  index of the main bird.
 all_done  out  1  round finished; no birds left.
 anim_cnt  out  10  frames elapsed in LOADING/FLYING; 0 otherwise.
 delta_x, delta_y  out  AIM_W  signed live aim offset.
 shot_dx, shot_dy  out  AIM_W  signed aim captured at launch.
 launch_pulse  out  1  one-clk pulse on entering FLYING.
 birds_left  out  4  birds not yet launched.

Function
REQ-008 All state, counter, aim and index updates SHALL occur only on clks with frame_tick=1; every output SHALL otherwise hold its value, except launch_pulse.
REQ-009 launch and restart SHALL each be latched into a pending flag on any clk; the flag SHALL clear on the next frame_tick, whether consumed or not.
REQ-010 A pending restart SHALL take priority over all other activity: active_bird=0, WAIT_LOAD, anim_cnt=0, deltas=0, shot_dx/dy=0, all_done=0, birds_left=NUM_BIRDS.
REQ-011 WAIT_LOAD: SHALL move to LOADING on the next tick, with anim_cnt=0.
REQ-012 LOADING: on each tick, anim_cnt SHALL increment; on the tick where anim_cnt==LOAD_FRAMES-1, the block SHALL enter AIM with anim_cnt=0.
REQ-013 AIM: on each tick, every aim axis SHALL update per REQ-016; a pending launch SHALL cause entry to FLYING, capture the same-tick updated delta_x/delta_y into shot_dx/shot_dy, zero both deltas, set anim_cnt=0, decrement birds_left, and assert launch_pulse for exactly that one clk.
REQ-014 Launch requests pending outside AIM SHALL be discarded.
REQ-015 FLYING: on each tick, anim_cnt SHALL increment; on a tick where anim_cnt==FLY_FRAMES-1 or settled=1, the bird SHALL end its flight: if active_bird<NUM_BIRDS-1, active_bird SHALL increment and the block SHALL enter WAIT_LOAD; otherwise all_done SHALL go to 1, bird_state SHALL go to WAIT_LOAD, and the block SHALL freeze until restart or reset.
REQ-016 Aim axis update: both opposing keys pressed, or neither, SHALL leave the axis unchanged. W alone SHALL subtract AIM_STEP from delta_y and S alone SHALL add it; A and D act likewise on delta_x. The result SHALL saturate to [-AIM_MAX, +AIM_MAX] independently per axis, so one axis at its limit never blocks the other.
REQ-017 Aim arithmetic SHALL use AIM_W+1 bits internally so that saturation never wraps.
REQ-018 When all_done=1, anim_cnt and both deltas SHALL be 0 and launch SHALL be ignored.

Reset
REQ-019 While rst=0, the block SHALL asynchronously hold: bird_state=WAIT_LOAD, active_bird=0, all_done=0, anim_cnt=0, all deltas=0, shot_dx/dy=0, launch_pulse=0, birds_left=NUM_BIRDS, pending flags cleared.
REQ-020 Reset deassertion mid-frame SHALL NOT advance state before the first subsequent frame_tick.

Structure
REQ-021 The bird_state encodings and the aim-key bit order SHALL live in the shared game package/header used by the bird, pig and collision blocks.
REQ-022 Per-axis saturating step logic SHALL be one sub-module, aim_axis, instantiated twice.

Verification
REQ-023 Defaults; release reset, apply ticks -> WAIT_LOAD for 1 tick, LOADING for 32 ticks (anim_cnt 0..31), then AIM at tick 33.
REQ-024 In AIM, hold D for 70 ticks and W for 5 ticks -> delta_x=+63 (saturated), delta_y=-5. With D and A both held, delta_x SHALL be unchanged.
REQ-025 Launch between ticks with delta_x=10, delta_y=-4 -> on the next tick: FLYING, shot_dx=10, shot_dy=-4, deltas=0, launch_pulse for 1 clk, birds_left=2.
REQ-026 FLYING with settled=0 -> exit on the tick where anim_cnt==480 and active_bird=1. With settled=1 at anim_cnt=20 -> exit on that tick.
REQ-027 Complete 3 flights -> all_done=1, birds_left=0, and later launches are ignored. Restart -> active_bird=0, WAIT_LOAD, birds_left=3.
REQ-028 Assert rst=0 mid-FLYING on a non-tick clk -> all outputs reach reset values immediately, without waiting for a clk edge.
